multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_ctrl_pkg.sv | 52 +++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: state encoding,
// opcode constants, ALUOp codes, ALU control codes and immediate selects.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ERROR    = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format implied by an opcode; anything not S/B/J uses the I layout.
   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_STORE:  imm_sel = IMM_S;
         OP_BRANCH: imm_sel = IMM_B;
         OP_JAL:    imm_sel = IMM_J;
         default:   imm_sel = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp, funct3, funct7 bit 5 and opcode bit 5.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op_b5,
   output logic [2:0] alu_control
);

   // Subtract only for R-type funct3=000 with funct7b5 set; I-type addi never subtracts.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller (Moore FSM plus ALU decode).
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a
// sticky ERROR state; otherwise they are skipped as a NOP back to FETCH.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       mem_req,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic [3:0] state,
   output logic       illegal_op
);

   state_t     state_q, state_d;
   logic [1:0] alu_op;

   // Next-state selection; memory states hold until mem_ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               default:           state_d = S_ERROR;
`else
               default:           state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         S_ERROR:    state_d = S_ERROR;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   // Sticky trap flag, set on entry to ERROR and only cleared by reset.
   always_comb begin
      illegal_d = illegal_q | (state_d == S_ERROR);
   end

   // State and trap flag registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   assign illegal_op = illegal_q;
`else
   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   assign illegal_op = 1'b0;
`endif

   assign state = state_q;

   // Per-state datapath controls; strobes are forced low while reset is held.
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      imm_src    = 2'b00;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = imm_sel(opcode);
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = ALUOP_SUB;
            pc_write  = zero;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         mem_req   = 1'b0;
      end
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op_b5       (opcode[5]),
      .alu_control (alu_control)
   );

endmodule
